// File: rtl/ext_in_cntrl_if.sv
// Byte handshake between an external device and the CPU IN-port controller.
interface ext_in_cntrl_if;
    logic [7:0] ext_data;
    logic       ext_valid;
    logic       ext_ready;

    modport master (output ext_data, output ext_valid, input ext_ready);
    modport slave  (input ext_data, input ext_valid, output ext_ready);
endinterface

// File: rtl/ext_in_cntrl.sv
// External IN port: device bytes queue in a small FIFO, the IN opcode pops the head.
// Latency: pushed byte visible on in_data the cycle after the push; read is zero-latency.
// Backpressure: ext_ready drops when full (registered count only); IN on empty raises in_stall.
module ext_in_cntrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    ext_in_cntrl_if.slave     ext,
    input  logic [3:0]        op,
    input  logic              pipe_en,
    output logic [7:0]        in_data,
    output logic              in_stall,
    output logic [AW:0]       count,
    output logic [7:0]        drop_cnt
);

    localparam logic [3:0]  OP_IN = 4'h7;
    localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          rdy_en;
    logic          is_in;
    logic          push;
    logic          pop;

    // rdy_en keeps ext_ready low during reset and for no longer than one edge after it
    assign ext.ext_ready = rdy_en & (count != FULL);

    assign is_in    = (op == OP_IN);
    assign push     = ext.ext_valid & ext.ext_ready;
    assign pop      = is_in & pipe_en & (count != '0);
    assign in_stall = is_in & (count == '0);
    assign in_data  = (count != '0) ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            rdy_en <= 1'b1;
            if (push) begin
                mem[wr_ptr] <= ext.ext_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (ext.ext_valid && !ext.ext_ready && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ext_in_cntrl.sv
// Scoreboard bench for ext_in_cntrl: bytes queued on acceptance, compared as the DUT pops them.
module tb_ext_in_cntrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] op;
    logic       pipe_en;
    logic [7:0] in_data;
    logic       in_stall;
    logic [2:0] count;
    logic [7:0] drop_cnt;

    ext_in_cntrl_if ext_bus ();

    ext_in_cntrl #(.DEPTH(4), .AW(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ext      (ext_bus),
        .op       (op),
        .pipe_en  (pipe_en),
        .in_data  (in_data),
        .in_stall (in_stall),
        .count    (count),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] sb_q[$];
    logic       m_rdy_ok;
    int         m_drop;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock: compare outputs at negedge, advance the model, then leave #1 after posedge.
    task automatic tick();
        logic       exp_rdy;
        logic       do_push;
        logic       do_pop;
        logic [7:0] head;
        @(negedge clk);
        exp_rdy = m_rdy_ok && (sb_q.size() != 4);
        head    = (sb_q.size() != 0) ? sb_q[0] : 8'h00;
        chk("ext_ready", 32'(ext_bus.ext_ready), 32'(exp_rdy));
        chk("count", 32'(count), 32'(sb_q.size()));
        chk("in_stall", 32'(in_stall), 32'((op == 4'h7) && (sb_q.size() == 0)));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        do_push = rst_n && ext_bus.ext_valid && exp_rdy;
        do_pop  = rst_n && (op == 4'h7) && pipe_en && (sb_q.size() != 0);
        if (do_pop) begin
            chk("pop_data", 32'(in_data), 32'(sb_q.pop_front()));
        end else begin
            chk("in_data", 32'(in_data), 32'(head));
        end
        if (do_push) sb_q.push_back(ext_bus.ext_data);
        if (rst_n && ext_bus.ext_valid && !exp_rdy && m_drop != 255) m_drop++;
        if (rst_n) m_rdy_ok = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        ext_bus.ext_valid = 1'b1;
        ext_bus.ext_data  = b;
        tick();
        ext_bus.ext_valid = 1'b0;
    endtask

    initial begin
        rst_n             = 1'b0;
        op                = 4'h0;
        pipe_en           = 1'b0;
        ext_bus.ext_valid = 1'b0;
        ext_bus.ext_data  = 8'h00;
        m_rdy_ok          = 1'b0;
        m_drop            = 0;

        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        // reset asserted with two bytes stored
        push_byte(8'h77);
        push_byte(8'h88);
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        m_rdy_ok = 1'b0;
        m_drop   = 0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(ext_bus.ext_ready), 32'd0);
        chk("rst_in_data", 32'(in_data), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ready_after_rel", 32'(ext_bus.ext_ready), 32'd1);
        tick();

        // fill to full, then hold a fifth byte against backpressure
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        ext_bus.ext_valid = 1'b1;
        ext_bus.ext_data  = 8'h55;
        repeat (3) tick();
        ext_bus.ext_valid = 1'b0;
        tick();
        chk("drop_full", 32'(drop_cnt), 32'd3);
        chk("full_count", 32'(count), 32'd4);

        // drain in order
        op      = 4'h7;
        pipe_en = 1'b1;
        repeat (4) tick();

        // empty stall, then a byte arrives while IN waits
        tick();
        push_byte(8'hA5);
        chk("stall_after_push", 32'(in_stall), 32'd0);
        chk("head_after_push", 32'(in_data), 32'hA5);
        tick();
        op = 4'h0;
        tick();

        // simultaneous push and pop at count=2, wrapping the pointers
        push_byte(8'h01);
        push_byte(8'h02);
        op      = 4'h7;
        pipe_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ext_bus.ext_valid = 1'b1;
            ext_bus.ext_data  = 8'(8'h10 + i);
            tick();
        end
        ext_bus.ext_valid = 1'b0;
        chk("pushpop_count", 32'(count), 32'd2);
        repeat (2) tick();
        op = 4'h0;
        tick();

        // pipe_en and opcode gating
        push_byte(8'hC3);
        op      = 4'h7;
        pipe_en = 1'b0;
        repeat (2) tick();
        op      = 4'h6;
        pipe_en = 1'b1;
        repeat (2) tick();
        chk("gated_count", 32'(count), 32'd1);
        op = 4'h7;
        tick();
        op = 4'h0;
        tick();

        // random traffic
        for (int i = 0; i < 60; i++) begin
            ext_bus.ext_valid = 1'($urandom_range(0, 1));
            ext_bus.ext_data  = 8'($urandom);
            op                = ($urandom_range(0, 2) != 0) ? 4'h7 : 4'($urandom_range(0, 15));
            pipe_en           = 1'($urandom_range(0, 3) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
